// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line containers, cache address fields and cache FSM states.
// Field widths below describe the default 8-set geometry.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int C_NUM_SETS = 8;
    localparam int C_OFFSET_W = 4;
    localparam int C_INDEX_W  = $clog2(C_NUM_SETS);
    localparam int C_TAG_W    = 16 - C_INDEX_W - C_OFFSET_W;

    typedef logic [C_TAG_W-1:0]    lc3b_c_tag;
    typedef logic [C_INDEX_W-1:0]  lc3b_c_index;
    typedef logic [C_OFFSET_W-1:0] lc3b_c_offset;

    typedef enum logic [1:0] {
        S_CHECK     = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } cache_state_t;

endpackage

// File: rtl/cache_control.sv
// L1 cache FSM: hit/miss decision, victim writeback and line fill sequencing.
// Hits respond combinationally; a stalled pmem_resp holds the FSM with its request raised.
module cache_control
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit,
    input  logic victim_dirty,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic in_check,
    output logic wb_done,
    output logic fill_done
);

    cache_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CHECK;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are suppressed while reset is sampled so an in-flight L2 reply is dropped.
    always_comb begin
        state_nxt  = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        in_check   = 1'b0;
        wb_done    = 1'b0;
        fill_done  = 1'b0;
        case (state)
            S_CHECK: begin
                in_check = 1'b1;
                if ((mem_read || mem_write) && !reset) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                    end else begin
                        state_nxt = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    wb_done   = !reset;
                    state_nxt = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_done = !reset;
                    state_nxt = S_CHECK;
                end
            end
            default: begin
                state_nxt = S_CHECK;
            end
        endcase
    end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1: 16-bit CPU word port, 128-bit L2 line port.
// Hit: same-cycle mem_resp; miss: optional writeback then fill, CPU held until mem_resp.
module l1_cache
    import lc3b_types::*;
#(
    parameter int NUM_SETS = C_NUM_SETS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 16 - IDX_W - C_OFFSET_W;

    lc3b_line         data_arr [NUM_SETS];
    logic [TAG_W-1:0] tag_arr  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_arr;
    logic [NUM_SETS-1:0] dirty_arr;

    logic [15:0]      miss_addr;
    logic [15:0]      cur_addr;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word_sel;
    lc3b_line         line;
    lc3b_line         wr_line;
    lc3b_word         sel_word;
    logic             hit;
    logic             victim_dirty;
    logic             in_check;
    logic             wb_done;
    logic             fill_done;
    logic             hit_write;

    cache_control u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .pmem_resp    (pmem_resp),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .in_check     (in_check),
        .wb_done      (wb_done),
        .fill_done    (fill_done)
    );

    // Miss handling works off the address captured at the miss, so a withdrawn
    // request still installs the line it asked for.
    assign cur_addr     = in_check ? mem_address : miss_addr;
    assign idx          = cur_addr[C_OFFSET_W +: IDX_W];
    assign tag          = cur_addr[15 -: TAG_W];
    assign word_sel     = cur_addr[3:1];
    assign line         = data_arr[idx];
    assign sel_word     = line[{word_sel, 4'h0} +: 16];
    assign hit          = valid_arr[idx] && (tag_arr[idx] == tag);
    assign victim_dirty = valid_arr[idx] && dirty_arr[idx];
    assign hit_write    = mem_resp && mem_write;

    assign mem_rdata    = mem_resp ? sel_word : 16'h0000;
    assign pmem_wdata   = line;
    assign pmem_address = pmem_write ? {tag_arr[idx], idx, 4'h0} : {tag, idx, 4'h0};

    always_comb begin
        wr_line = line;
        if (mem_byte_enable[0]) begin
            wr_line[{word_sel, 4'h0} +: 8] = mem_wdata[7:0];
        end
        if (mem_byte_enable[1]) begin
            wr_line[{word_sel, 4'h8} +: 8] = mem_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (in_check) begin
            miss_addr <= mem_address;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_arr <= '0;
            dirty_arr <= '0;
        end else if (fill_done) begin
            valid_arr[idx] <= 1'b1;
            dirty_arr[idx] <= 1'b0;
        end else if (wb_done) begin
            dirty_arr[idx] <= 1'b0;
        end else if (hit_write) begin
            dirty_arr[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[idx] <= pmem_rdata;
            tag_arr[idx]  <= tag;
        end else if (hit_write) begin
            data_arr[idx] <= wr_line;
        end
    end

endmodule
